// File: rtl/complex_addsub_pipe_pkg.sv
// rtl/complex_addsub_pipe_pkg.sv - mode encodings and W+1 -> W reduction for the complex add/sub unit
package cadd_pkg;

  typedef enum logic [1:0] {
    CADD_ADD  = 2'b00,
    CADD_SUB  = 2'b01,
    CADD_ADDJ = 2'b10,
    CADD_SUBJ = 2'b11
  } cadd_mode_e;

  localparam int CADD_MAX_W = 64;
  localparam logic signed [CADD_MAX_W:0] CADD_ONE = (CADD_MAX_W + 1)'(1);

  // s is a sign-extended W+1-bit sum; the low w bits of the result are meaningful.
  function automatic logic [CADD_MAX_W-1:0] cadd_reduce(
    input  logic signed [CADD_MAX_W:0] s,
    input  int                         w,
    input  bit                         sat,
    output logic                       ovf
  );
    logic signed [CADD_MAX_W:0] hi;
    logic signed [CADD_MAX_W:0] lo;
    hi  = (CADD_ONE << (w - 1)) - CADD_ONE;
    lo  = -hi - CADD_ONE;
    ovf = (s > hi) || (s < lo);
    if (sat && (s > hi)) return hi[CADD_MAX_W-1:0];
    if (sat && (s < lo)) return lo[CADD_MAX_W-1:0];
    return s[CADD_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/complex_addsub_pipe_if.sv
// rtl/complex_addsub_pipe_if.sv - handshake and data bundle of the complex add/sub unit
interface complex_addsub_pipe_if #(
  parameter int W     = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [W-1:0]     a_re;
  logic [W-1:0]     a_img;
  logic [W-1:0]     b_re;
  logic [W-1:0]     b_img;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     c_re;
  logic [W-1:0]     c_img;
  logic [TAG_W-1:0] out_tag;
  logic             ovf;

  modport master (
    output in_valid, mode, a_re, a_img, b_re, b_img, in_tag, out_ready,
    input  in_ready, out_valid, c_re, c_img, out_tag, ovf
  );

  modport slave (
    input  in_valid, mode, a_re, a_img, b_re, b_img, in_tag, out_ready,
    output in_ready, out_valid, c_re, c_img, out_tag, ovf
  );
endinterface

// File: rtl/complex_addsub_pipe_lane.sv
// rtl/complex_addsub_pipe_lane.sv - one real add/sub lane; CADD_SAT_EN selects saturate instead of wrap
module cadd_lane
  import cadd_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W:0]   sum_o,
  input  logic [W:0]   red_sum_i,
  output logic [W-1:0] res_o,
  output logic         ovf_o
);
`ifdef CADD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [W:0]                 a_x;
  logic [W:0]                 b_x;
  logic signed [CADD_MAX_W:0] ext;
  logic [CADD_MAX_W-1:0]      red;
  logic                       unused_hi;

  // One guard bit means even 0 - (-2^(W-1)) cannot overflow here.
  assign a_x   = {a_i[W-1], a_i};
  assign b_x   = {b_i[W-1], b_i};
  assign sum_o = sub_i ? (a_x - b_x) : (a_x + b_x);

  // Reduction runs on whichever raw sum the pipeline presents, not necessarily this cycle's.
  assign ext = (CADD_MAX_W + 1)'($signed(red_sum_i));

  always_comb begin
    ovf_o = 1'b0;
    red   = cadd_reduce(ext, W, SAT, ovf_o);
  end

  assign res_o     = red[W-1:0];
  assign unused_hi = ^red[CADD_MAX_W-1:W];
endmodule

// File: rtl/complex_addsub_pipe.sv
// rtl/complex_addsub_pipe.sv - pipelined complex a+b, a-b, a+jb, a-jb with tag passthrough (CADD_SAT_EN: saturate)
module complex_addsub_pipe
  import cadd_pkg::*;
#(
  parameter int W      = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  complex_addsub_pipe_if.slave   io
);
  localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("complex_addsub_pipe: STAGES must be in 1..4");
  end
  if (W < 2 || W >= CADD_MAX_W) begin : g_bad_width
    $error("complex_addsub_pipe: W out of range");
  end

  logic stall;
  logic accept;

  assign stall       = io.out_valid & ~io.out_ready;
  assign io.in_ready = ~stall;
  assign accept      = io.in_valid & ~stall;

  logic [W-1:0] re_b;
  logic [W-1:0] im_b;
  logic         re_sub;
  logic         im_sub;

  // +-j modes swap B's components into the opposite lanes.
  always_comb begin
    re_b   = io.b_re;
    im_b   = io.b_img;
    re_sub = 1'b0;
    im_sub = 1'b0;
    case (io.mode)
      CADD_SUB:  begin re_sub = 1'b1; im_sub = 1'b1; end
      CADD_ADDJ: begin re_b = io.b_img; im_b = io.b_re; re_sub = 1'b1; end
      CADD_SUBJ: begin re_b = io.b_img; im_b = io.b_re; im_sub = 1'b1; end
      default:   ;
    endcase
  end

  logic [W:0]       raw_re_d;
  logic [W:0]       raw_im_d;
  logic [W:0]       red_re_in;
  logic [W:0]       red_im_in;
  logic             red_vld_in;
  logic [TAG_W-1:0] red_tag_in;
  logic [W-1:0]     res_re;
  logic [W-1:0]     res_im;
  logic             ovf_re;
  logic             ovf_im;

  cadd_lane #(.W(W)) u_lane_re (
    .a_i(io.a_re), .b_i(re_b), .sub_i(re_sub), .sum_o(raw_re_d),
    .red_sum_i(red_re_in), .res_o(res_re), .ovf_o(ovf_re)
  );

  cadd_lane #(.W(W)) u_lane_im (
    .a_i(io.a_img), .b_i(im_b), .sub_i(im_sub), .sum_o(raw_im_d),
    .red_sum_i(red_im_in), .res_o(res_im), .ovf_o(ovf_im)
  );

  if (STAGES == 1) begin : g_direct
    assign red_re_in  = raw_re_d;
    assign red_im_in  = raw_im_d;
    assign red_vld_in = accept;
    assign red_tag_in = io.in_tag;
  end else begin : g_raw
    logic             v1_q;
    logic [W:0]       re1_q;
    logic [W:0]       im1_q;
    logic [TAG_W-1:0] tag1_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v1_q   <= 1'b0;
        re1_q  <= '0;
        im1_q  <= '0;
        tag1_q <= '0;
      end else if (!stall) begin
        v1_q   <= accept;
        re1_q  <= raw_re_d;
        im1_q  <= raw_im_d;
        tag1_q <= io.in_tag;
      end
    end

    assign red_re_in  = re1_q;
    assign red_im_in  = im1_q;
    assign red_vld_in = v1_q;
    assign red_tag_in = tag1_q;
  end

  logic             v_q   [NR];
  logic [W-1:0]     re_q  [NR];
  logic [W-1:0]     im_q  [NR];
  logic             ovf_q [NR];
  logic [TAG_W-1:0] tag_q [NR];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NR; k++) begin
        v_q[k]   <= 1'b0;
        re_q[k]  <= '0;
        im_q[k]  <= '0;
        ovf_q[k] <= 1'b0;
        tag_q[k] <= '0;
      end
    end else if (!stall) begin
      v_q[0]   <= red_vld_in;
      re_q[0]  <= res_re;
      im_q[0]  <= res_im;
      ovf_q[0] <= ovf_re | ovf_im;
      tag_q[0] <= red_tag_in;
      for (int k = 1; k < NR; k++) begin
        v_q[k]   <= v_q[k-1];
        re_q[k]  <= re_q[k-1];
        im_q[k]  <= im_q[k-1];
        ovf_q[k] <= ovf_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign io.out_valid = v_q[NR-1];
  assign io.c_re      = re_q[NR-1];
  assign io.c_img     = im_q[NR-1];
  assign io.ovf       = ovf_q[NR-1];
  assign io.out_tag   = tag_q[NR-1];
endmodule

// File: doc/complex_addsub_pipe.md
Name: complex_addsub_pipe

Overview:
- Parametrised, pipelined complex add/subtract unit for the FFT butterfly datapath.
- Operates on fixed-point two's-complement samples, not floating point.
- Supports four per-transaction modes: a+b, a−b, a+jb and a−jb. The ±j modes cover the trivial twiddles in radix-4 and radix-5 stages.
- Valid/ready handshake with full backpressure, plus a tag passthrough so sample indices travel alongside the data.

Parameters:
- W, 16, width of each real/imag component, input and output.
- STAGES, 2, pipeline depth (1..4); equals the latency in cycles when not stalled.
- TAG_W, 4, width of the sideband tag carried alongside each sample.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  unit can accept an input this cycle.
- mode  in  2  operation select: 00 a+b, 01 a−b, 10 a+jb, 11 a−jb.
- a_re, a_img  in  W each  operand A.
- b_re, b_img  in  W each  operand B.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- c_re, c_img  out  W each  result.
- out_tag  out  TAG_W  tag of the current result.
- ovf  out  1  overflow on c_re or c_img of the current result; qualified by out_valid.

Behaviour:
- Arithmetic per mode:
  - 00: c_re = a_re + b_re; c_img = a_img + b_img.
  - 01: c_re = a_re − b_re; c_img = a_img − b_img.
  - 10: c_re = a_re − b_img; c_img = a_img + b_re.
  - 11: c_re = a_re + b_img; c_img = a_img − b_re.
- Sums are computed at W+1 bits and then reduced to W bits (wrap or saturate, see Optional Feature).
- mode, operands and tag are sampled together on an input handshake (in_valid & in_ready).
- Pipeline:
  - STAGES register slices, each holding a valid bit, data and tag.
  - Stage 1 holds the W+1-bit raw sums for both lanes.
  - The last stage holds the reduced W-bit result and ovf.
  - Any further stages are plain delay slices.
- Stall and ready:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - While stalled, every stage holds its contents: no loss, no duplication.
  - When not stalled, all stages advance each cycle. Bubbles propagate with valid = 0.
- Latency: a sample accepted in cycle t appears at the output in cycle t+STAGES when no stall occurs. Throughput is one sample per cycle.
- Outputs change only on advance, so c_*/out_tag/ovf are stable while out_valid & ~out_ready.
- Ordering: results leave strictly in acceptance order, and tags are never reordered.
- Reset (rst_n low at a clk edge):
  - All valid bits, data, tags and ovf are cleared to 0.
  - Reset overrides a simultaneous handshake; in-flight samples are discarded.
  - in_ready is 1 in the first cycle after reset is released.
- Simultaneous events: an input handshake and an output handshake in the same cycle are both honoured (a full pipeline moves one step).
- Boundary values: mode 01 with b = −2^(W−1) takes the W+1-bit path correctly; no intermediate overflow at W+1 bits.
- Illegal STAGES (<1 or >4): elaboration error.

Optional Feature:
- Macro: CADD_SAT_EN.
- Defined: each lane saturates to [−2^(W−1), 2^(W−1)−1]. ovf = 1 when either lane clamped.
- Undefined: each lane wraps modulo 2^W (the W LSBs of the sum). ovf still reports that the sum did not fit in W bits, but the output is the wrapped value.
- Port list is identical in both builds.

Decomposition:
- Package cadd_pkg:
  - Mode constants CADD_ADD=2'b00, CADD_SUB=2'b01, CADD_ADDJ=2'b10, CADD_SUBJ=2'b11.
  - Function for the W+1→W reduction (saturate or wrap).
- Sub-module cadd_lane: one real add/sub (operand negation select, W+1-bit sum, reduction, overflow detect). Instantiated twice, for the re and imag lanes.
- The top level holds the operand cross-select for the ±j modes, the pipeline slices and the handshake.

Test Plan:
- W=16, STAGES=2, out_ready=1; mode 00, a=(100,−50), b=(25,75), tag 3 → c=(125,25), out_tag 3, ovf=0, exactly 2 cycles after acceptance.
- mode 10, a=(10,20), b=(3,4) → c=(6,23); mode 11 with the same operands → c=(14,17); mode 01 → c=(7,16).
- mode 00, a_re=32767, b_re=1: with CADD_SAT_EN c_re=32767, ovf=1; without it c_re=−32768, ovf=1. mode 01, a_re=0, b_re=−32768 → saturate to 32767 / wrap to −32768.
- Stream of 8 back-to-back samples (tags 0..7); out_ready low for 3 cycles mid-stream → in_ready low during the stall, outputs held stable, all 8 results delivered in tag order with none lost or duplicated.
- Pipeline full with 2 samples, then rst_n low for 1 cycle → out_valid=0, c/out_tag/ovf=0 next cycle; in_ready=1 after release; no stale results ever appear.
- STAGES=1 and STAGES=4 builds: random 1000-sample stream with random out_ready → results match the reference model, and latency equals STAGES whenever unstalled.
